// File: rtl/serial_adder_fsm.sv
// -----------------------------------------------------------------------------
// serial_adder_fsm
//
// Multi-bit serial adder under FSM control. A start request latches two
// WIDTH-bit operands and a carry-in. The block then adds BITS_PER_CYCLE bits per
// clock, LSB slice first, and rolls the carry through a carry register. After
// N = WIDTH/BITS_PER_CYCLE RUN cycles it reports the sum, the carry-out and a
// done flag. It holds those results until it is cleared or restarted.
//
// Parameters
//   WIDTH           operand/sum width in bits (>= 1)
//   BITS_PER_CYCLE  bits added per RUN cycle; must divide WIDTH exactly
//
// Ports
//   clk    in   1      rising-edge clock
//   NRST   in   1      asynchronous active-low reset
//   start  in   1      begin an operation (level, honoured in IDLE and DONE)
//   rst    in   1      synchronous soft clear back to IDLE; beats start
//   CIN    in   1      carry-in, latched with the operands
//   A, B   in   WIDTH  operands, latched on an accepted start
//   sub    in   1      (SERIAL_ADDER_SUB_EN only) 1 = compute A - B
//   S      out  WIDTH  sum; valid while done=1
//   COUT   out  1      final carry-out (no-borrow when subtracting); valid while done=1
//   busy   out  1      high in RUN
//   done   out  1      high in DONE
//
// Optional feature
//   Define SERIAL_ADDER_SUB_EN to add the sub input. When sub=1 the adder
//   computes A + ~B + 1 and ignores CIN.
// -----------------------------------------------------------------------------
module serial_adder_fsm #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             NRST,
    input  logic             start,
    input  logic             rst,
    input  logic             CIN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             busy,
    output logic             done
);

    localparam int BPC   = (BITS_PER_CYCLE > 0) ? BITS_PER_CYCLE : 1;
    localparam int N     = (WIDTH / BPC > 0) ? (WIDTH / BPC) : 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    // Reject geometries where the slices would not tile the operand exactly.
    if ((WIDTH < 1) || (BITS_PER_CYCLE < 1) || ((WIDTH % BPC) != 0)) begin : g_param_check
        $error("serial_adder_fsm: WIDTH must be >= 1 and a multiple of BITS_PER_CYCLE");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One slice of the ripple: BPC-bit add plus carry-in. Returns {carry, sum}.
    function automatic logic [BPC:0] slice_add(
        input logic [BPC-1:0] a_slice,
        input logic [BPC-1:0] b_slice,
        input logic           c_in
    );
        slice_add = {1'b0, a_slice} + {1'b0, b_slice} + {{BPC{1'b0}}, c_in};
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic             carry_r;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH-1:0] load_b_s;
    logic             load_c_s;
    logic [BPC-1:0]   slice_a_s;
    logic [BPC-1:0]   slice_b_s;
    logic [BPC:0]     slice_sum_s;

    // Operand B and the initial carry as they will be latched. Subtraction folds
    // into the same adder as A + ~B + 1.
    always_comb begin
        load_b_s = B;
        load_c_s = CIN;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            load_b_s = ~B;
            load_c_s = 1'b1;
        end else begin
            load_b_s = B;
            load_c_s = CIN;
        end
`endif
    end

    // Select the current slice of the latched operands and add it.
    always_comb begin
        slice_a_s   = opa_r[idx_r * BPC +: BPC];
        slice_b_s   = opb_r[idx_r * BPC +: BPC];
        slice_sum_s = slice_add(slice_a_s, slice_b_s, carry_r);
    end

    // Control FSM together with the datapath registers and the registered outputs.
    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            state_r <= ST_IDLE;
            opa_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
            s_r     <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (rst) begin
            // Soft clear discards any in-flight operation. Start is not honoured.
            state_r <= ST_IDLE;
            opa_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
            s_r     <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        opa_r   <= A;
                        opb_r   <= load_b_s;
                        carry_r <= load_c_s;
                        idx_r   <= {IDX_W{1'b0}};
                        s_r     <= {WIDTH{1'b0}};
                        cout_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    // start is deliberately not looked at here.
                    s_r[idx_r * BPC +: BPC] <= slice_sum_s[BPC-1:0];
                    carry_r                 <= slice_sum_s[BPC];
                    idx_r                   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    if (idx_r == LAST_IDX) begin
                        cout_r  <= slice_sum_s[BPC];
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end

                ST_DONE: begin
                    if (start) begin
                        // Back-to-back: re-latch and go straight to RUN.
                        opa_r   <= A;
                        opb_r   <= load_b_s;
                        carry_r <= load_c_s;
                        idx_r   <= {IDX_W{1'b0}};
                        s_r     <= {WIDTH{1'b0}};
                        cout_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= {IDX_W{1'b0}};
                    s_r     <= {WIDTH{1'b0}};
                    cout_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign S    = s_r;
    assign COUT = cout_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_fsm
//
// Self-checking bench for serial_adder_fsm. It uses two instances:
//   u_dut1  WIDTH=8, BITS_PER_CYCLE=1 (N=8)
//   u_dut2  WIDTH=8, BITS_PER_CYCLE=4 (N=2)
// The expected results come from plain integer arithmetic on the requested
// operands: {COUT,S} = A + B + CIN, or A + ~B + 1 when subtracting.
// -----------------------------------------------------------------------------
module tb_serial_adder_fsm;

    logic       clk;
    logic       NRST;

    logic       start1, rst1, cin1;
    logic [7:0] a1, b1, s1;
    logic       cout1, busy1, done1;

    logic       start2, rst2, cin2;
    logic [7:0] a2, b2, s2;
    logic       cout2, busy2, done2;

`ifdef SERIAL_ADDER_SUB_EN
    logic       sub1, sub2;
`endif

    int checks;
    int errors;

    serial_adder_fsm #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk   (clk),
        .NRST  (NRST),
        .start (start1),
        .rst   (rst1),
        .CIN   (cin1),
        .A     (a1),
        .B     (b1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub1),
`endif
        .S     (s1),
        .COUT  (cout1),
        .busy  (busy1),
        .done  (done1)
    );

    serial_adder_fsm #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut2 (
        .clk   (clk),
        .NRST  (NRST),
        .start (start2),
        .rst   (rst2),
        .CIN   (cin2),
        .A     (a2),
        .B     (b2),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub2),
`endif
        .S     (s2),
        .COUT  (cout2),
        .busy  (busy2),
        .done  (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] get_s(input int sel);
        return (sel == 2) ? s2 : s1;
    endfunction
    function automatic logic get_cout(input int sel);
        return (sel == 2) ? cout2 : cout1;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel == 2) ? busy2 : busy1;
    endfunction
    function automatic logic get_done(input int sel);
        return (sel == 2) ? done2 : done1;
    endfunction

    task automatic drive(input int sel, input logic st, input logic [7:0] av,
                         input logic [7:0] bv, input logic cv, input logic sv);
        if (sel == 2) begin
            start2 = st; a2 = av; b2 = bv; cin2 = cv;
`ifdef SERIAL_ADDER_SUB_EN
            sub2 = sv;
`endif
        end else begin
            start1 = st; a1 = av; b1 = bv; cin1 = cv;
`ifdef SERIAL_ADDER_SUB_EN
            sub1 = sv;
`endif
        end
        if (sv) begin
        end
    endtask

    // One full operation. It checks acceptance, latency, the result and busy.
    // With churn set, start and the operands keep changing during RUN.
    task automatic run_op(input string tag, input int sel, input logic [7:0] av,
                          input logic [7:0] bv, input logic cv, input logic sv,
                          input bit churn);
        logic [8:0] exp;
        int         n;
        int         lat;
        exp = sv ? ({1'b0, av} + {1'b0, ~bv} + 9'd1)
                 : ({1'b0, av} + {1'b0, bv} + {8'd0, cv});
        lat = (sel == 2) ? 2 : 8;
        drive(sel, 1'b1, av, bv, cv, sv);
        @(posedge clk); #1;
        // Operands change right after the accepting edge; result must not care.
        drive(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        chk({tag, "_busy_on_accept"}, 32'(get_busy(sel)), 32'd1);
        chk({tag, "_done_on_accept"}, 32'(get_done(sel)), 32'd0);
        n = 0;
        while ((n < 40) && (get_done(sel) !== 1'b1)) begin
            if (churn) begin
                drive(sel, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            end
            @(posedge clk); #1;
            n++;
        end
        drive(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_S"}, 32'(get_s(sel)), 32'(exp[7:0]));
        chk({tag, "_COUT"}, 32'(get_cout(sel)), 32'(exp[8]));
        chk({tag, "_busy_in_done"}, 32'(get_busy(sel)), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        NRST   = 1'b0;
        rst1   = 1'b0;
        rst2   = 1'b0;
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(2, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Reset state.
        #12;
        chk("rst_S1",    32'(s1),    32'd0);
        chk("rst_COUT1", 32'(cout1), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_done1", 32'(done1), 32'd0);
        chk("rst_S2",    32'(s2),    32'd0);
        chk("rst_done2", 32'(done2), 32'd0);
        @(negedge clk);
        NRST = 1'b1;
        @(posedge clk); #1;

        // Directed additions.
        run_op("t2_5a_33", 1, 8'h5A, 8'h33, 1'b1, 1'b0, 1'b0);
        run_op("t3_ff_ff", 1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t3_hold_S",    32'(s1),    32'hFF);
            chk("t3_hold_done", 32'(done1), 32'd1);
        end
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        chk("t3_rst_S",    32'(s1),    32'd0);
        chk("t3_rst_done", 32'(done1), 32'd0);
        chk("t3_rst_COUT", 32'(cout1), 32'd0);

        // Soft clear at the third RUN cycle, then start and rst together.
        drive(1, 1'b1, 8'h10, 8'h01, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1, 1'b0, 8'h10, 8'h01, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t4_busy_before_rst", 32'(busy1), 32'd1);
        rst1 = 1'b1;
        @(posedge clk); #1;
        chk("t4_rst_busy", 32'(busy1), 32'd0);
        chk("t4_rst_S",    32'(s1),    32'd0);
        chk("t4_rst_done", 32'(done1), 32'd0);
        drive(1, 1'b1, 8'h22, 8'h11, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("t4_start_rst_busy", 32'(busy1), 32'd0);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        rst1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t4_no_done", 32'(done1), 32'd0);
        end

        // Back-to-back start from DONE, with start toggling during RUN.
        run_op("t5_first", 1, 8'h37, 8'h48, 1'b0, 1'b0, 1'b0);
        run_op("t5_b2b", 1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1);

        // Async reset in the middle of RUN, checked before the next edge.
        drive(1, 1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t1_busy_pre", 32'(busy1), 32'd1);
        NRST = 1'b0;
        #1;
        chk("t1_async_busy", 32'(busy1), 32'd0);
        chk("t1_async_done", 32'(done1), 32'd0);
        chk("t1_async_S",    32'(s1),    32'd0);
        chk("t1_async_COUT", 32'(cout1), 32'd0);
        #2;
        NRST = 1'b1;
        @(posedge clk); #1;
        chk("t1_stays_idle", 32'(busy1), 32'd0);

        // Randomised additions against the arithmetic model.
        for (int i = 0; i < 16; i++) begin
            run_op("rand1", 1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'($urandom));
        end

        // Four bits per cycle.
        run_op("t6_9c_71", 2, 8'h9C, 8'h71, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_op("rand2", 2, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
        end
`ifdef SERIAL_ADDER_SUB_EN
        run_op("t6_sub_05_07", 2, 8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
        run_op("sub_07_05", 1, 8'h07, 8'h05, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_op("rand_sub", 1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
